// File: rtl/wb_stage_if.sv
// Memory-stage to write-back handshake, data-bus read response and regfile write port.
// The master drives the memory-stage side. The slave is the wb_stage side.
interface wb_stage_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_wa;
  logic        mem_wreg;
  logic [31:0] mem_wd;
  logic        mem_is_load;
  logic [2:0]  mem_ld_type;
  logic [1:0]  mem_addr_lo;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        flush;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        we;
  logic        stall_req;
  logic        bus_err;

  modport master (
    output mem_valid, mem_wa, mem_wreg, mem_wd, mem_is_load, mem_ld_type, mem_addr_lo,
    output rdata_valid, rdata, flush,
    input  mem_ready, wa, wd, we, stall_req, bus_err
  );

  modport slave (
    input  mem_valid, mem_wa, mem_wreg, mem_wd, mem_is_load, mem_ld_type, mem_addr_lo,
    input  rdata_valid, rdata, flush,
    output mem_ready, wa, wd, we, stall_req, bus_err
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: registers non-load results and waits for load data with a timeout.
// Register writes are emitted one cycle after the event that produces them.
module wb_stage #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       cpu_clk_50M,
  input  logic       cpu_rst,
  wb_stage_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  ld_wa_q, ld_wa_d;
  logic        ld_wreg_q, ld_wreg_d;
  logic [2:0]  ld_type_q, ld_type_d;
  logic [1:0]  ld_lo_q, ld_lo_d;
  logic        we_q, we_d;
  logic [4:0]  wa_q, wa_d;
  logic [31:0] wd_q, wd_d;
  logic        bus_err_q, bus_err_d;
  logic        mem_ready_s;
  logic        accept_s;

  // Unknown load type codes behave as LW.
  function automatic logic [31:0] align_load(input logic [2:0]  ld_type,
                                             input logic [1:0]  addr_lo,
                                             input logic [31:0] word);
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    case (addr_lo)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      default: byte_s = word[31:24];
    endcase
    half_s = addr_lo[1] ? word[31:16] : word[15:0];
    case (ld_type)
      3'b000:  return {{24{byte_s[7]}}, byte_s};
      3'b001:  return {24'h000000, byte_s};
      3'b010:  return {{16{half_s[15]}}, half_s};
      3'b011:  return {16'h0000, half_s};
      default: return word;
    endcase
  endfunction

  assign mem_ready_s   = (state_q == ST_IDLE) && !bus.flush && !cpu_rst;
  assign accept_s      = bus.mem_valid && mem_ready_s;
  assign bus.mem_ready = mem_ready_s;
  assign bus.stall_req = (state_q == ST_WAIT);
  assign bus.we        = we_q;
  assign bus.wa        = wa_q;
  assign bus.wd        = wd_q;
  assign bus.bus_err   = bus_err_q;

  // Next-state, load context and regfile write decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_wa_d   = ld_wa_q;
    ld_wreg_d = ld_wreg_q;
    ld_type_d = ld_type_q;
    ld_lo_d   = ld_lo_q;
    we_d      = 1'b0;
    wa_d      = wa_q;
    wd_d      = wd_q;
    bus_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && bus.mem_is_load) begin
          ld_wa_d   = bus.mem_wa;
          ld_wreg_d = bus.mem_wreg;
          ld_type_d = bus.mem_ld_type;
          ld_lo_d   = bus.mem_addr_lo;
          cnt_d     = 8'd0;
          state_d   = ST_WAIT;
        end else if (accept_s && bus.mem_wreg && (bus.mem_wa != 5'd0)) begin
          we_d = 1'b1;
          wa_d = bus.mem_wa;
          wd_d = bus.mem_wd;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Flush beats a response in the same cycle; a response beats the timeout.
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (bus.rdata_valid) begin
          state_d = ST_IDLE;
          if (ld_wreg_q && (ld_wa_q != 5'd0)) begin
            we_d = 1'b1;
            wa_d = ld_wa_q;
            wd_d = align_load(ld_type_q, ld_lo_q, bus.rdata);
          end else begin
            we_d = 1'b0;
          end
        end else if ((cnt_q + 8'd1) >= TIMEOUT_LIM) begin
          cnt_d     = cnt_q + 8'd1;
          state_d   = ST_IDLE;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      ld_wa_q   <= 5'd0;
      ld_wreg_q <= 1'b0;
      ld_type_q <= 3'd0;
      ld_lo_q   <= 2'd0;
      we_q      <= 1'b0;
      wa_q      <= 5'd0;
      wd_q      <= 32'h0000_0000;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_wa_q   <= ld_wa_d;
      ld_wreg_q <= ld_wreg_d;
      ld_type_q <= ld_type_d;
      ld_lo_q   <= ld_lo_d;
      we_q      <= we_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
Parameters:
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: maximum cycles spent in WAIT before a load is abandoned (legal 1..255).
Ports (name  direction  width  meaning):
REQ-002 SHALL have cpu_clk_50M  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have cpu_rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have mem_valid  input  1  memory stage presents an instruction.
REQ-005 SHALL have mem_ready  output  1  wb_stage accepts the presented instruction this cycle.
REQ-006 SHALL have mem_wa  input  5  destination register address.
REQ-007 SHALL have mem_wreg  input  1  instruction writes a register.
REQ-008 SHALL have mem_wd  input  32  non-load result value.
REQ-009 SHALL have mem_is_load  input  1  instruction is a load.
REQ-010 SHALL have mem_ld_type  input  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW; other codes are treated as LW.
REQ-011 SHALL have mem_addr_lo  input  2  byte offset of the load address.
REQ-012 SHALL have rdata_valid  input  1  data-bus read response valid (single-cycle pulse).
REQ-013 SHALL have rdata  input  32  data-bus read word, little-endian.
REQ-014 SHALL have flush  input  1  discard the accepted or presented instruction.
REQ-015 SHALL have wa / wd / we  output  5 / 32 / 1  regfile write port.
REQ-016 SHALL have stall_req  output  1  high while waiting for load data.
REQ-017 SHALL have bus_err  output  1  one-cycle pulse when a load times out.

Function
REQ-018 SHALL implement FSM states IDLE and WAIT; mem_ready = (state==IDLE) && !flush; stall_req = (state==WAIT).
REQ-019 SHALL accept on mem_valid && mem_ready; an accepted non-load drives we/wa/wd in the next cycle (1-cycle latency, registered outputs), enabling back-to-back acceptance every cycle.
REQ-020 SHALL, on accepting a load, latch wa, wreg, ld_type, addr_lo, clear the timeout counter and enter WAIT; we stays 0 that next cycle.
REQ-021 SHALL, in WAIT, on rdata_valid, register the aligned load result: we = latched wreg, in the following cycle, and return to IDLE.
REQ-022 SHALL align loads: LB/LBU select byte addr_lo (byte 0 = rdata[7:0]), sign/zero-extend; LH/LHU select half addr_lo[1], sign/zero-extend; LW passes rdata; addr_lo[0] ignored for halves, addr_lo ignored for LW.
REQ-023 SHALL force we = 0 whenever the write address is 0, regardless of wreg.
REQ-024 SHALL pulse we for exactly one cycle per written instruction; wa/wd hold last values when we = 0.
REQ-025 SHALL increment an 8-bit counter each WAIT cycle without rdata_valid; on reaching TIMEOUT_CYC: return to IDLE, pulse bus_err, no write.
REQ-026 SHALL give rdata_valid priority over timeout in the same cycle (write performed, no bus_err).
REQ-027 SHALL, on flush in WAIT, return to IDLE with no write and no bus_err; flush in IDLE blocks acceptance of that cycle's instruction.
REQ-028 SHALL ignore rdata_valid while in IDLE (late responses after flush/timeout are dropped).
REQ-029 SHALL NOT cancel a write already registered for the next cycle when flush arrives.

Reset
REQ-030 SHALL, with cpu_rst high at a clock edge, set state IDLE, counter 0, we 0, wa 0, wd 0x00000000, bus_err 0; mid-WAIT reset abandons the load with no write.
REQ-031 SHALL hold mem_ready 0 during cycles where cpu_rst is high.

Verification
REQ-032 Non-load mem_wa=5, mem_wd=0x12345678, wreg=1 accepted at cycle N -> we=1, wa=5, wd=0x12345678 at N+1 only.
REQ-033 LB, addr_lo=2, rdata=0x00F30000 with rdata_valid 3 cycles later -> stall_req high 3 cycles, then wd=0xFFFFFFF3; LBU same -> 0x000000F3; LH addr_lo=2, rdata=0x8001xxxx -> 0xFFFF8001.
REQ-034 TIMEOUT_CYC=4, load with no response -> bus_err pulse after 4 WAIT cycles, no we; rdata_valid next cycle ignored.
REQ-035 Flush during WAIT, then rdata_valid -> no we, mem_ready returns 1 next cycle.
REQ-036 Non-load with mem_wa=0, wreg=1 -> we stays 0; cpu_rst asserted mid-WAIT -> all outputs at reset values next cycle, later rdata_valid ignored.
